servo_valve_sequencer: RTL and testbench
========================================

# servo_valve_sequencer

Timed valve-actuation sequencer that drives `set_bit` of the servo PWM interface, which sits directly downstream. It accepts a one-cycle open command with a hold duration in milliseconds. It holds the valve open for the servo settle time plus that duration, closes it, and waits a second settle time before reporting completion. Every servo move therefore finishes before the next command is accepted. Abort support lets the flow controller force an early close.

## Interface
- `TICK_DIV`, 100000: clk cycles per 1 ms tick (100 MHz clk); must be ≥ 2.
- `SETTLE_MS`, 300: servo travel/settle time in ms, applied after both open and close; must be ≥ 1.
- `DUR_W`, 16: width of `dur_ms`.

- `clk`, in, 1: system clock; all state changes on the rising edge.
- `clr_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: open command; sampled only in IDLE.
- `dur_ms`, in, DUR_W: hold time in ms after open-settle; latched when `start` is accepted.
- `abort`, in, 1: force early close; level-sampled each cycle.
- `set_bit`, out, 1: valve-open request to the servo interface (1 = open position).
- `busy`, out, 1: sequence in progress; `start` is ignored while high.
- `done`, out, 1: one-cycle completion pulse.
- `aborted`, out, 1: last sequence ended via abort; valid from `done` until the next accepted `start`.

## Operation
- States:
  - IDLE
  - OPEN_SETTLE: `set_bit`=1, runs SETTLE_MS ms.
  - HOLD: `set_bit`=1, runs latched `dur_ms` ms.
  - CLOSE_SETTLE: `set_bit`=0, runs SETTLE_MS ms.
- All outputs are registered. The reset value of `set_bit`, `busy`, `done` and `aborted` is 0, and the reset state is IDLE.
- Tick prescaler: counts 0..TICK_DIV-1 and produces a tick on terminal count. It is cleared on every state entry and held at 0 in IDLE. Its width is clog2(TICK_DIV).
- Phase counter: DUR_W bits wide, loaded on state entry with the phase length in ms, and decremented on each tick. The phase ends on the tick that takes it from 1 to 0.
- IDLE + `start`: latch `dur_ms`, clear `aborted`, enter OPEN_SETTLE, set `busy`=1.
- OPEN_SETTLE end:
  - enter HOLD;
  - if latched `dur_ms`=0, enter CLOSE_SETTLE directly (valve still fully settles open first).
- HOLD end: enter CLOSE_SETTLE.
- CLOSE_SETTLE end: enter IDLE, with `busy`=0 and `done`=1 on the same edge. `done` returns to 0 on the next edge.
- `abort` in OPEN_SETTLE or HOLD:
  - next edge enters CLOSE_SETTLE with a full SETTLE_MS;
  - `aborted` is set with the `done` pulse.
- `abort` in CLOSE_SETTLE or IDLE: ignored.
- Simultaneous events:
  - `start`+`abort` in IDLE: `start` accepted, `abort` ignored that cycle.
  - `abort` on the same edge as the OPEN_SETTLE→HOLD or OPEN_SETTLE→CLOSE_SETTLE transition: `abort` wins; go to CLOSE_SETTLE and set `aborted` at `done`.
  - `start` during the `done` cycle: state is IDLE, so it is accepted.
- `dur_ms` changes while `busy`: no effect.
- `clr_n` low mid-sequence: `set_bit` drops to 0 immediately (asynchronous). The sequence is discarded and no `done` is issued. After release, the block waits for a new `start`. A valve left partially open by the reset is closed by the downstream PWM at its next frame.

## Timing
- Accepting edge E (the edge that samples `start`): `set_bit`=1 and `busy`=1 from edge E.
- Normal completion:
  - `set_bit` falls at edge E + (SETTLE_MS + dur_ms)·TICK_DIV;
  - `done` is high for exactly one cycle beginning at edge E + (2·SETTLE_MS + dur_ms)·TICK_DIV.
- Abort sampled at edge A (A > E, state OPEN_SETTLE or HOLD):
  - `set_bit`=0 from edge A;
  - `done` at edge A + SETTLE_MS·TICK_DIV.
- Minimum sequence, `dur_ms`=0: `done` at E + 2·SETTLE_MS·TICK_DIV.
- Maximum `dur_ms`=2^DUR_W-1: no counter wrap. The phase counter is never loaded above its width.
- Back-to-back: a `start` held high continuously restarts at the `done` edge. The resulting `set_bit` low window is SETTLE_MS·TICK_DIV cycles.

## Test plan
- TICK_DIV=4, SETTLE_MS=2, `start` pulse with `dur_ms`=3 at edge 10 → `set_bit` 1 over edges 10..29 and 0 at 30; `done` high only at edge 38; `aborted`=0.
- Same parameters, `dur_ms`=0 → `set_bit` falls at edge 18; `done` at edge 26.
- `dur_ms`=5, `abort` pulse at edge 20 (HOLD) → `set_bit`=0 at 20; `done` at 28; `aborted`=1. The next `start` clears `aborted`.
- `start` pulses while `busy`, plus `abort` during CLOSE_SETTLE → no effect on timing; exactly one `done` per accepted `start`.
- `clr_n` driven low asynchronously mid-HOLD → `set_bit`, `busy`, `done`, `aborted` go to 0 before the next clock edge. No `done` is issued. A `start` after release gives the nominal timing.
- `start` held high continuously with `dur_ms`=1 → back-to-back sequences with `done` every 20 cycles; `set_bit` low for exactly 8 cycles between opens.

Source files
------------

// File: rtl/servo_valve_sequencer.sv
// ---------------------------------------------------------------------------
// servo_valve_sequencer
//
// Timed valve-actuation sequencer feeding set_bit of the downstream servo PWM
// interface. A one-cycle start opens the valve, lets it settle for SETTLE_MS,
// holds it for the latched dur_ms, closes it, lets it settle for SETTLE_MS
// again and then pulses done. abort forces an early close (with a full close
// settle) while the valve is opening or holding.
//
// Parameters
//   TICK_DIV  : clk cycles per 1 ms tick (>= 2)
//   SETTLE_MS : servo travel/settle time in ms after open and after close (>= 1)
//   DUR_W     : width of dur_ms and of the phase counter
//
// Ports
//   clk      in   system clock, rising edge
//   clr_n    in   asynchronous active-low reset
//   start    in   open command, sampled only in IDLE (or on the completing edge)
//   dur_ms   in   hold time in ms, latched when start is accepted
//   abort    in   force early close, level-sampled in OPEN_SETTLE / HOLD
//   set_bit  out  valve-open request (1 = open)
//   busy     out  sequence in progress
//   done     out  one-cycle completion pulse
//   aborted  out  last sequence ended via abort (valid from done on)
// ---------------------------------------------------------------------------
module servo_valve_sequencer #(
    parameter int TICK_DIV  = 100000,
    parameter int SETTLE_MS = 300,
    parameter int DUR_W     = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [DUR_W-1:0] dur_ms,
    input  logic             abort,
    output logic             set_bit,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] SETTLE_LD = DUR_W'(SETTLE_MS);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        OPEN_SETTLE  = 2'd1,
        HOLD         = 2'd2,
        CLOSE_SETTLE = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic [PW-1:0]    pre_q,     pre_d;
    logic [DUR_W-1:0] phase_q,   phase_d;
    logic [DUR_W-1:0] dur_q,     dur_d;
    logic             ab_q,      ab_d;      // current sequence was aborted
    logic             set_bit_q, set_bit_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             aborted_q, aborted_d;

    logic tick_s;
    logic phase_end_s;

    // Millisecond tick and end-of-phase detection
    always_comb begin
        tick_s      = (pre_q == PRE_LAST);
        phase_end_s = tick_s && (phase_q == DUR_W'(1));
    end

    // Next-state logic for the sequencer and its registered outputs
    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
        ab_d      = ab_q;
        set_bit_d = set_bit_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;

        // Free-running prescaler/phase countdown while a phase is active;
        // every state entry below overrides these with fresh values.
        if (state_q == IDLE) begin
            pre_d   = {PW{1'b0}};
            phase_d = phase_q;
        end else if (tick_s) begin
            pre_d   = {PW{1'b0}};
            phase_d = phase_q - DUR_W'(1);
        end else begin
            pre_d   = pre_q + PW'(1);
            phase_d = phase_q;
        end

        case (state_q)
            IDLE: begin
                // abort is ignored here, start always wins
                if (start) begin
                    state_d   = OPEN_SETTLE;
                    dur_d     = dur_ms;
                    ab_d      = 1'b0;
                    aborted_d = 1'b0;
                    set_bit_d = 1'b1;
                    busy_d    = 1'b1;
                    pre_d     = {PW{1'b0}};
                    phase_d   = SETTLE_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            OPEN_SETTLE: begin
                // abort takes priority over a coincident end of the open settle
                if (abort || (phase_end_s && (dur_q == {DUR_W{1'b0}}))) begin
                    state_d   = CLOSE_SETTLE;
                    ab_d      = abort;
                    set_bit_d = 1'b0;
                    pre_d     = {PW{1'b0}};
                    phase_d   = SETTLE_LD;
                end else if (phase_end_s) begin
                    state_d = HOLD;
                    pre_d   = {PW{1'b0}};
                    phase_d = dur_q;
                end else begin
                    state_d = OPEN_SETTLE;
                end
            end
            HOLD: begin
                if (abort || phase_end_s) begin
                    state_d   = CLOSE_SETTLE;
                    ab_d      = abort;
                    set_bit_d = 1'b0;
                    pre_d     = {PW{1'b0}};
                    phase_d   = SETTLE_LD;
                end else begin
                    state_d = HOLD;
                end
            end
            CLOSE_SETTLE: begin
                if (phase_end_s) begin
                    done_d    = 1'b1;
                    aborted_d = ab_q;
                    // A start already high on the completing edge restarts
                    // immediately, so a held start gives back-to-back
                    // sequences with exactly one close-settle of valve-closed
                    // time. aborted keeps reporting the finished sequence.
                    if (start) begin
                        state_d   = OPEN_SETTLE;
                        dur_d     = dur_ms;
                        ab_d      = 1'b0;
                        set_bit_d = 1'b1;
                        busy_d    = 1'b1;
                        pre_d     = {PW{1'b0}};
                        phase_d   = SETTLE_LD;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    state_d = CLOSE_SETTLE;
                end
            end
            default: begin
                state_d   = IDLE;
                set_bit_d = 1'b0;
                busy_d    = 1'b0;
                pre_d     = {PW{1'b0}};
            end
        endcase
    end

    // State and output registers; reset discards any sequence in flight
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            pre_q     <= {PW{1'b0}};
            phase_q   <= {DUR_W{1'b0}};
            dur_q     <= {DUR_W{1'b0}};
            ab_q      <= 1'b0;
            set_bit_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            phase_q   <= phase_d;
            dur_q     <= dur_d;
            ab_q      <= ab_d;
            set_bit_q <= set_bit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign set_bit = set_bit_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_servo_valve_sequencer.sv
// ---------------------------------------------------------------------------
// tb_servo_valve_sequencer
//
// Directed bench with TICK_DIV=4, SETTLE_MS=2. Each scenario numbers clock
// edges from a local origin, records the outputs just after every edge, and
// then compares the trace against hand-computed edge numbers.
// ---------------------------------------------------------------------------
module tb_servo_valve_sequencer;

    localparam int TD = 4;
    localparam int SM = 2;
    localparam int DW = 8;
    localparam int NE = 128;

    logic          clk;
    logic          clr_n;
    logic          start;
    logic [DW-1:0] dur_ms;
    logic          abort;
    logic          set_bit;
    logic          busy;
    logic          done;
    logic          aborted;

    int n_checks;
    int n_errors;
    int edge_n;

    logic sb_r [NE];
    logic dn_r [NE];
    logic ab_r [NE];
    logic by_r [NE];

    servo_valve_sequencer #(
        .TICK_DIV  (TD),
        .SETTLE_MS (SM),
        .DUR_W     (DW)
    ) u_dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (start),
        .dur_ms  (dur_ms),
        .abort   (abort),
        .set_bit (set_bit),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start a new edge numbering origin and clear the trace
    task automatic new_origin();
        edge_n = 0;
        for (int i = 0; i < NE; i++) begin
            sb_r[i] = 1'b0;
            dn_r[i] = 1'b0;
            ab_r[i] = 1'b0;
            by_r[i] = 1'b0;
        end
    endtask

    // Advance to edge n, sampling outputs 1 time unit after each edge
    task automatic run_to(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            edge_n++;
            #1;
            sb_r[edge_n] = set_bit;
            dn_r[edge_n] = done;
            ab_r[edge_n] = aborted;
            by_r[edge_n] = busy;
        end
    endtask

    function automatic int cnt_done(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(dn_r[i]);
        return c;
    endfunction

    function automatic int cnt_open(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(sb_r[i]);
        return c;
    endfunction

    // One start pulse sampled at edge e
    task automatic pulse_start(input int e, input int d);
        run_to(e - 1);
        start  = 1'b1;
        dur_ms = DW'(d);
        run_to(e);
        start  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        dur_ms   = '0;
        new_origin();

        #3;
        chk("rst_set_bit", int'(set_bit), 0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_done",    int'(done),    0);
        chk("rst_aborted", int'(aborted), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        // Nominal: dur 3, start at 10 -> open 10..29, closed at 30, done 38
        new_origin();
        pulse_start(10, 3);
        run_to(45);
        chk("n_open_before", int'(sb_r[9]), 0);
        chk("n_open_window", cnt_open(10, 29), 20);
        chk("n_close_30",    int'(sb_r[30]), 0);
        chk("n_busy_10",     int'(by_r[10]), 1);
        chk("n_done_37",     int'(dn_r[37]), 0);
        chk("n_done_38",     int'(dn_r[38]), 1);
        chk("n_done_count",  cnt_done(1, 45), 1);
        chk("n_busy_38",     int'(by_r[38]), 0);
        chk("n_aborted",     int'(ab_r[38]), 0);

        // Minimum: dur 0 -> closed at 18, done at 26
        new_origin();
        pulse_start(10, 0);
        run_to(35);
        chk("z_open_17",    int'(sb_r[17]), 1);
        chk("z_close_18",   int'(sb_r[18]), 0);
        chk("z_done_26",    int'(dn_r[26]), 1);
        chk("z_done_count", cnt_done(1, 35), 1);

        // Abort in HOLD at 20 -> closed at 20, done 28 with aborted; next start clears
        new_origin();
        pulse_start(10, 5);
        run_to(19);
        abort = 1'b1;
        run_to(20);
        abort = 1'b0;
        pulse_start(40, 1);
        run_to(65);
        chk("a_open_19",     int'(sb_r[19]), 1);
        chk("a_close_20",    int'(sb_r[20]), 0);
        chk("a_done_28",     int'(dn_r[28]), 1);
        chk("a_aborted_28",  int'(ab_r[28]), 1);
        chk("a_aborted_35",  int'(ab_r[35]), 1);
        chk("a_aborted_clr", int'(ab_r[40]), 0);
        chk("a_done_60",     int'(dn_r[60]), 1);
        chk("a_aborted_60",  int'(ab_r[60]), 0);
        chk("a_done_count",  cnt_done(1, 65), 2);

        // Starts while busy and abort in CLOSE_SETTLE are ignored
        new_origin();
        pulse_start(10, 2);
        pulse_start(15, 7);
        pulse_start(25, 7);
        run_to(29);
        abort = 1'b1;
        run_to(30);
        abort = 1'b0;
        run_to(55);
        chk("b_open_25",    int'(sb_r[25]), 1);
        chk("b_close_26",   int'(sb_r[26]), 0);
        chk("b_done_34",    int'(dn_r[34]), 1);
        chk("b_aborted_34", int'(ab_r[34]), 0);
        chk("b_done_count", cnt_done(1, 55), 1);

        // Asynchronous reset mid-HOLD, then a fresh nominal sequence
        new_origin();
        pulse_start(10, 5);
        run_to(22);
        #2;
        clr_n = 1'b0;
        #1;
        chk("r_set_bit_async", int'(set_bit), 0);
        chk("r_busy_async",    int'(busy),    0);
        chk("r_done_async",    int'(done),    0);
        chk("r_aborted_async", int'(aborted), 0);
        run_to(24);
        clr_n = 1'b1;
        run_to(60);
        chk("r_no_done", cnt_done(23, 60), 0);
        chk("r_no_open", cnt_open(23, 60), 0);
        new_origin();
        pulse_start(10, 3);
        run_to(45);
        chk("r_open_window", cnt_open(10, 29), 20);
        chk("r_close_30",    int'(sb_r[30]), 0);
        chk("r_done_38",     int'(dn_r[38]), 1);
        chk("r_done_count",  cnt_done(1, 45), 1);

        // Held start, dur 1 -> done at 30, 50, 70; closed for 8 edges each gap
        new_origin();
        run_to(9);
        dur_ms = DW'(1);
        start  = 1'b1;
        run_to(75);
        start  = 1'b0;
        run_to(100);
        chk("h_open_21",    int'(sb_r[21]), 1);
        chk("h_close_22",   int'(sb_r[22]), 0);
        chk("h_closed_gap", cnt_open(22, 29), 0);
        chk("h_reopen_30",  int'(sb_r[30]), 1);
        chk("h_done_30",    int'(dn_r[30]), 1);
        chk("h_done_50",    int'(dn_r[50]), 1);
        chk("h_done_70",    int'(dn_r[70]), 1);
        chk("h_closed_run", (40 - cnt_open(30, 69)), 16);
        chk("h_done_count", cnt_done(1, 75), 3);
        chk("h_busy_31",    int'(by_r[31]), 1);
        chk("h_done_90",    int'(dn_r[90]), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
